exec_unit: RTL
==============

# exec_unit

Registered, handshaked execute stage for the CPU core, successor to the combinational data-processing ALU. It adds a barrel shifter on operand 2, an internal NZCV flag register that feeds ADC/SBC/RSC carry-in, and an iterative MUL/MLA path. It is generalised over data width. It sits between decode/register-read and writeback, accepting one operation at a time over a valid/ready pair.

## Interface
- DATA_WIDTH, 32, operand/result width (≥4, power of two)
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept (high only in IDLE)
- is_mul  in  1  1: multiply path, opcode ignored
- accumulate  in  1  with is_mul: MLA (add operand3)
- opcode  in  4  data-processing opcode, standard ARM encoding (AND=0 … MVN=15)
- operand1  in  DATA_WIDTH  Rn / multiplicand
- operand2  in  DATA_WIDTH  Rm before shift / multiplier
- operand3  in  DATA_WIDTH  MLA accumulate value
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- shift_amount  in  SHAMT_WIDTH  0 = no shift
- set_flags  in  1  S suffix: update NZCV at completion
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- result  out  DATA_WIDTH  registered result
- write_result  out  1  0 for TST/TEQ/CMP/CMN, else 1
- nzcv  out  4  flag register {N,Z,C,V}

## Operation
- FSM: IDLE, MUL, DONE. Reset and post-reset state is IDLE.
- IDLE with in_valid: capture all inputs.
  - ALU op: go to DONE.
  - MUL: go to MUL with counter = 0.
- MUL: one shift-add step per cycle, LSB-first over operand2. After DATA_WIDTH steps go to DONE. The product is the low DATA_WIDTH bits; add operand3 if accumulate.
- DONE: out_valid = 1. If out_ready, go to IDLE. result and write_result stay stable while out_valid && !out_ready.
- Shifter (ALU ops only), amount n:
  - LSL: out = b << n, sc = b[W-n].
  - LSR: out = b >> n, sc = b[n-1].
  - ASR: out = arithmetic shift, sc = b[n-1].
  - ROR: out = rotate, sc = b[n-1].
  - n = 0: out = b, sc = current C.
  - Shifted value is B below.
- Arithmetic uses a DATA_WIDTH+1-bit sum; C is bit DATA_WIDTH.
  - SUB/CMP: A + ~B + 1.
  - RSB: B + ~A + 1.
  - ADD/CMN: A + B.
  - ADC: A + B + C.
  - SBC: A + ~B + C.
  - RSC: B + ~A + C.
  - C therefore means "no borrow" on subtracts.
- V:
  - For add forms, V = (x[msb] == y[msb]) && (r[msb] != x[msb]), where x, y are the actual addends (~B or ~A for subtract forms).
  - Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = sc, V unchanged.
- MUL/MLA: N and Z updated; C and V unchanged.
- Flags are written only when set_flags = 1, and only on the edge entering DONE.
  - N = result[msb], Z = (result == 0).
  - TST/TEQ/CMP/CMN compute flags with write_result = 0; their result output still carries the computed value.
- Carry-in for ADC/SBC/RSC and sc at n = 0 use nzcv as it stands when the operation is accepted.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, write_result 0, nzcv 4'b0000, MUL counter 0.
- ALU latency: accept on edge k; out_valid and flags visible after edge k+1.
- MUL latency: accept on edge k; out_valid after edge k+DATA_WIDTH+1.
- Throughput:
  - in_ready is low from the accept edge until the edge on which DONE handshakes (out_valid && out_ready).
  - in_ready is high the cycle after a handshake.
  - No overlap: 1 op per 2 cycles for ALU, DATA_WIDTH+2 for MUL.
- Back-to-back dependency: flags from op i are guaranteed visible to op i+1, because op i+1 cannot be accepted before op i completes.
- in_valid in any state other than IDLE is ignored; inputs are not re-sampled.
- Async rst_n low at any point, including mid-MUL or DONE stall:
  - All state returns to reset values immediately.
  - The in-flight op is discarded with no flag update.

## Test plan
- Reset mid-MUL: assert rst_n low at cycle 5 of a MUL → out_valid 0, nzcv 0000, in_ready 1, no later spurious out_valid.
- ADDS 0x7FFFFFFF + 1, shift LSL #0 → result 0x80000000, nzcv 1001, out_valid one cycle after accept.
- SUBS 5 − 5, then SBC 3 − 1 with C taken from the SUBS → SUBS nzcv 0110; SBC result 2 (C = 1 means no borrow).
- MOVS operand2 = 0x80000001, LSR #1 → result 0x40000000, C = 1, V unchanged from prior value; CMP 1, 2 → write_result 0, nzcv 1000.
- MLAS 0xFFFFFFFF × 2 + 3 → result 0x00000001, N = 0, Z = 0, C and V unchanged; out_valid exactly DATA_WIDTH+1 cycles after accept.
- out_ready held low 4 cycles in DONE → result stable, in_ready low; a new op is accepted only the cycle after the handshake.

Source files
------------

// File: rtl/exec_unit.sv
// Registered, handshaked execute stage: data-processing ALU with operand-2 barrel
// shifter, NZCV flag register, and an iterative shift-add MUL/MLA path.
module exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   is_mul,
    input  logic                   accumulate,
    input  logic [3:0]             opcode,
    input  logic [DATA_WIDTH-1:0]  operand1,
    input  logic [DATA_WIDTH-1:0]  operand2,
    input  logic [DATA_WIDTH-1:0]  operand3,
    input  logic [1:0]             shift_type,
    input  logic [SHAMT_WIDTH-1:0] shift_amount,
    input  logic                   set_flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   write_result,
    output logic [3:0]             nzcv
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [SHAMT_WIDTH-1:0] CNT_LAST = {SHAMT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SHAMT_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]  r_mcand;
    logic [DATA_WIDTH-1:0]  r_mplier;
    logic [DATA_WIDTH-1:0]  r_acc;
    logic                   r_set_flags;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_write_result;
    logic [3:0]             r_nzcv;

    logic [SHAMT_WIDTH-1:0] w_neg_n;
    logic [SHAMT_WIDTH-1:0] w_n_m1;
    logic [DATA_WIDTH-1:0]  w_sh;
    logic                   w_sc;
    logic [DATA_WIDTH-1:0]  w_x;
    logic [DATA_WIDTH-1:0]  w_y;
    logic                   w_cin;
    logic                   w_arith;
    logic [DATA_WIDTH-1:0]  w_logic;
    logic [DATA_WIDTH:0]    w_sum;
    logic                   w_v;
    logic [DATA_WIDTH-1:0]  w_alu_res;
    logic [3:0]             w_alu_nzcv;
    logic                   w_alu_wr;
    logic [DATA_WIDTH-1:0]  w_mul_acc_next;

    // For n >= 1, -n mod W is W-n (the last bit LSL shifts out) and n-1 indexes the
    // last bit the right shifts/rotate shift out.
    assign w_neg_n = ~shift_amount + {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
    assign w_n_m1  = shift_amount - {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    // Barrel shifter on operand 2 with shifter carry-out
    always_comb begin
        w_sh = operand2;
        w_sc = r_nzcv[1];
        if (shift_amount != {SHAMT_WIDTH{1'b0}}) begin
            case (shift_type)
                2'b00: begin
                    w_sh = operand2 << shift_amount;
                    w_sc = operand2[w_neg_n];
                end
                2'b01: begin
                    w_sh = operand2 >> shift_amount;
                    w_sc = operand2[w_n_m1];
                end
                2'b10: begin
                    w_sh = $signed(operand2) >>> shift_amount;
                    w_sc = operand2[w_n_m1];
                end
                2'b11: begin
                    w_sh = (operand2 >> shift_amount) | (operand2 << w_neg_n);
                    w_sc = operand2[w_n_m1];
                end
                default: begin
                    w_sh = operand2;
                    w_sc = r_nzcv[1];
                end
            endcase
        end else begin
            w_sh = operand2;
            w_sc = r_nzcv[1];
        end
    end

    // Operand steering for the single adder and logical result selection
    always_comb begin
        w_x     = operand1;
        w_y     = w_sh;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        w_logic = operand1 & w_sh;
        case (opcode)
            4'd0, 4'd8:  w_logic = operand1 & w_sh;
            4'd1, 4'd9:  w_logic = operand1 ^ w_sh;
            4'd2, 4'd10: begin w_arith = 1'b1; w_y = ~w_sh; w_cin = 1'b1; end
            4'd3:        begin w_arith = 1'b1; w_x = w_sh; w_y = ~operand1; w_cin = 1'b1; end
            4'd4, 4'd11: w_arith = 1'b1;
            4'd5:        begin w_arith = 1'b1; w_cin = r_nzcv[1]; end
            4'd6:        begin w_arith = 1'b1; w_y = ~w_sh; w_cin = r_nzcv[1]; end
            4'd7:        begin w_arith = 1'b1; w_x = w_sh; w_y = ~operand1; w_cin = r_nzcv[1]; end
            4'd12:       w_logic = operand1 | w_sh;
            4'd13:       w_logic = w_sh;
            4'd14:       w_logic = operand1 & ~w_sh;
            4'd15:       w_logic = ~w_sh;
            default:     w_logic = operand1 & w_sh;
        endcase
    end

    assign w_sum      = {1'b0, w_x} + {1'b0, w_y} + {{DATA_WIDTH{1'b0}}, w_cin};
    assign w_v        = (w_x[MSB] == w_y[MSB]) && (w_sum[MSB] != w_x[MSB]);
    assign w_alu_res  = w_arith ? w_sum[MSB:0] : w_logic;
    assign w_alu_wr   = (opcode[3:2] != 2'b10);
    assign w_alu_nzcv = {w_alu_res[MSB], (w_alu_res == {DATA_WIDTH{1'b0}}),
                         (w_arith ? w_sum[DATA_WIDTH] : w_sc),
                         (w_arith ? w_v : r_nzcv[0])};

    assign w_mul_acc_next = r_acc + (r_mplier[0] ? r_mcand : {DATA_WIDTH{1'b0}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = is_mul ? ST_MUL : ST_DONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, multiply steps, result/flag write on entering DONE.
    // MLA preloads the accumulator with operand3 so the final add is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= {SHAMT_WIDTH{1'b0}};
            r_mcand        <= {DATA_WIDTH{1'b0}};
            r_mplier       <= {DATA_WIDTH{1'b0}};
            r_acc          <= {DATA_WIDTH{1'b0}};
            r_set_flags    <= 1'b0;
            r_result       <= {DATA_WIDTH{1'b0}};
            r_write_result <= 1'b0;
            r_nzcv         <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && is_mul) begin
                        r_mcand        <= operand1;
                        r_mplier       <= operand2;
                        r_acc          <= accumulate ? operand3 : {DATA_WIDTH{1'b0}};
                        r_cnt          <= {SHAMT_WIDTH{1'b0}};
                        r_set_flags    <= set_flags;
                        r_write_result <= 1'b1;
                    end else if (in_valid) begin
                        r_result       <= w_alu_res;
                        r_write_result <= w_alu_wr;
                        if (set_flags) begin
                            r_nzcv <= w_alu_nzcv;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_mul_acc_next;
                    r_mcand  <= {r_mcand[MSB-1:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[MSB:1]};
                    r_cnt    <= r_cnt + {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
                    if (r_cnt == CNT_LAST) begin
                        r_result <= w_mul_acc_next;
                        if (r_set_flags) begin
                            r_nzcv <= {w_mul_acc_next[MSB],
                                       (w_mul_acc_next == {DATA_WIDTH{1'b0}}),
                                       r_nzcv[1:0]};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign result       = r_result;
    assign write_result = r_write_result;
    assign nzcv         = r_nzcv;

endmodule
